gmii_frame_gen: RTL and testbench

GMII_FRAME_GEN -- requirements
Module: gmii_frame_gen

---
 rtl/gmii_frame_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_gmii_frame_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_frame_gen.sv
// GMII test-frame generator: bursts of preamble/SFD/payload frames separated by
// an inter-packet gap, with selectable payload pattern and optional TX_ER injection.
module gmii_frame_gen #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IPG_LEN      = 12,
  parameter int LEN_W        = 11,
  parameter int CNT_W        = 8
) (
  input  logic             Clk,
  input  logic             mr_main_reset,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [CNT_W-1:0] num_frames,
  input  logic [1:0]       mode,
  input  logic [7:0]       seed,
  input  logic             err_en,
  input  logic [LEN_W-1:0] err_idx,
  output logic [7:0]       TXD,
  output logic             TX_EN,
  output logic             TX_ER,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int CW = (LEN_W > 8) ? LEN_W : 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SFD  = 3'd2,
    S_DATA = 3'd3,
    S_IPG  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] nfr_q, nfr_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       seed_q, seed_d;
  logic             err_en_q, err_en_d;
  logic [LEN_W-1:0] err_idx_q, err_idx_d;
  logic [7:0]       pat_q, pat_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [7:0]       txd_q, txd_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_er_q, tx_er_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_byte_s;

  // Galois step for x^8+x^6+x^5+x^4+1, right-shifting form.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    if (v[0]) begin
      lfsr_step = (v >> 3'd1) ^ 8'hB8;
    end else begin
      lfsr_step = v >> 3'd1;
    end
  endfunction

  assign last_byte_s = ((cnt_q + CW'(1'b1)) == CW'(len_q));

  // State register
  always_ff @(posedge Clk) begin
    if (!mr_main_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_frames == {CNT_W{1'b0}}) ? S_FIN : S_PRE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        if (cnt_q == CW'(PREAMBLE_LEN - 1)) state_d = S_SFD;
        else                                state_d = S_PRE;
      end
      S_SFD: begin
        if (len_q == {LEN_W{1'b0}}) state_d = S_IPG;
        else                        state_d = S_DATA;
      end
      S_DATA: begin
        if (last_byte_s) state_d = S_IPG;
        else             state_d = S_DATA;
      end
      S_IPG: begin
        if (cnt_q == CW'(IPG_LEN - 1)) begin
          state_d = (frames_q < nfr_q) ? S_PRE : S_FIN;
        end else begin
          state_d = S_IPG;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, latched configuration and payload pattern
  always_comb begin
    cnt_d     = cnt_q;
    len_d     = len_q;
    nfr_d     = nfr_q;
    mode_d    = mode_q;
    seed_d    = seed_q;
    err_en_d  = err_en_q;
    err_idx_d = err_idx_q;
    pat_d     = pat_q;
    frames_d  = frames_q;

    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
    end

    if ((state_q == S_IDLE) && start) begin
      len_d     = frame_len;
      nfr_d     = num_frames;
      mode_d    = mode;
      seed_d    = seed;
      err_en_d  = err_en;
      err_idx_d = err_idx;
      frames_d  = {CNT_W{1'b0}};
    end else if ((state_d == S_IPG) && (state_q != S_IPG) && (frames_q < nfr_q)) begin
      frames_d = frames_q + CNT_W'(1'b1);
    end else begin
      frames_d = frames_q;
    end

    // Pattern reloads in SFD so every frame restarts from the seed.
    if (state_q == S_SFD) begin
      if ((mode_q == 2'b10) && (seed_q == 8'h00)) pat_d = 8'h01;
      else                                        pat_d = seed_q;
    end else if (state_q == S_DATA) begin
      case (mode_q)
        2'b01:   pat_d = pat_q;
        2'b10:   pat_d = lfsr_step(pat_q);
        default: pat_d = pat_q + 8'd1;
      endcase
    end else begin
      pat_d = pat_q;
    end
  end

  // Output decode; GMII lines are registered so they trail the state by one cycle
  always_comb begin
    txd_d   = 8'h00;
    tx_en_d = 1'b0;
    tx_er_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    case (state_q)
      S_PRE: begin
        txd_d   = 8'h55;
        tx_en_d = 1'b1;
      end
      S_SFD: begin
        txd_d   = 8'hD5;
        tx_en_d = 1'b1;
      end
      S_DATA: begin
        txd_d   = pat_q;
        tx_en_d = 1'b1;
        tx_er_d = err_en_q && (cnt_q == CW'(err_idx_q)) && (err_idx_q < len_q);
      end
      default: begin
        txd_d   = 8'h00;
        tx_en_d = 1'b0;
        tx_er_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clk) begin
    if (!mr_main_reset) begin
      cnt_q     <= {CW{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      nfr_q     <= {CNT_W{1'b0}};
      mode_q    <= 2'b00;
      seed_q    <= 8'h00;
      err_en_q  <= 1'b0;
      err_idx_q <= {LEN_W{1'b0}};
      pat_q     <= 8'h00;
      frames_q  <= {CNT_W{1'b0}};
      txd_q     <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      nfr_q     <= nfr_d;
      mode_q    <= mode_d;
      seed_q    <= seed_d;
      err_en_q  <= err_en_d;
      err_idx_q <= err_idx_d;
      pat_q     <= pat_d;
      frames_q  <= frames_d;
      txd_q     <= txd_d;
      tx_en_q   <= tx_en_d;
      tx_er_q   <= tx_er_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign TXD         = txd_q;
  assign TX_EN       = tx_en_q;
  assign TX_ER       = tx_er_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Directed bench for gmii_frame_gen with default parameters (7 preamble, 12 IPG).
module tb_gmii_frame_gen;
  logic        Clk = 1'b0;
  logic        mr_main_reset;
  logic        start;
  logic [10:0] frame_len;
  logic [7:0]  num_frames;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic        err_en;
  logic [10:0] err_idx;
  logic [7:0]  TXD;
  logic        TX_EN;
  logic        TX_ER;
  logic        busy;
  logic        done;
  logic [7:0]  frames_sent;

  int errors = 0;
  int checks = 0;

  gmii_frame_gen dut (
    .Clk(Clk), .mr_main_reset(mr_main_reset), .start(start),
    .frame_len(frame_len), .num_frames(num_frames), .mode(mode), .seed(seed),
    .err_en(err_en), .err_idx(err_idx), .TXD(TXD), .TX_EN(TX_EN), .TX_ER(TX_ER),
    .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic setup(input logic [10:0] l, input logic [7:0] nf, input logic [1:0] m,
                       input logic [7:0] s, input logic ee, input logic [10:0] ei);
    frame_len = l; num_frames = nf; mode = m; seed = s; err_en = ee; err_idx = ei;
  endtask

  initial begin
    int n;
    int pos;
    int er_cnt;
    int en_cnt;
    logic prev_en;
    logic [7:0] exp_b;

    mr_main_reset = 1'b0;
    start = 1'b1;
    setup(11'd4, 8'd1, 2'b00, 8'h10, 1'b0, 11'd0);
    // Reset held with start asserted: block must stay idle and cleared
    tick(); tick();
    chk("rst_txd", 32'(TXD), 32'h00);
    chk("rst_en", 32'(TX_EN), 32'd0);
    chk("rst_er", 32'(TX_ER), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    start = 1'b0;
    mr_main_reset = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic frame, mode 00 seed 0x10 len 4; inputs scrambled after start
    start = 1'b1;
    tick();
    start = 1'b0;
    setup(11'd9, 8'd5, 2'b10, 8'hFF, 1'b1, 11'd1);
    chk("s1_latency_en", 32'(TX_EN), 32'd0);
    chk("s1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_b = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'(8'h10 + i - 8);
      chk("s1_en", 32'(TX_EN), 32'd1);
      chk("s1_txd", 32'(TXD), 32'(exp_b));
      chk("s1_er", 32'(TX_ER), 32'd0);
    end
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("s1_ipg_en", 32'(TX_EN), 32'd0);
      chk("s1_ipg_txd", 32'(TXD), 32'h00);
      chk("s1_ipg_done", 32'(done), 32'd0);
    end
    tick();
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_frames", 32'(frames_sent), 32'd1);
    chk("s1_fin_busy", 32'(busy), 32'd1);
    tick();
    chk("s1_done_pulse", 32'(done), 32'd0);
    chk("s1_idle", 32'(busy), 32'd0);

    // PRBS mode with zero seed: LFSR starts at 0x01
    setup(11'd3, 8'd1, 2'b10, 8'h00, 1'b0, 11'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    tick(); chk("s2_b0", 32'(TXD), 32'h01); chk("s2_er0", 32'(TX_ER), 32'd0);
    tick(); chk("s2_b1", 32'(TXD), 32'hB8); chk("s2_er1", 32'(TX_ER), 32'd0);
    tick(); chk("s2_b2", 32'(TXD), 32'h5C); chk("s2_er2", 32'(TX_ER), 32'd0);
    wait_done("s2_done", n);
    tick();

    // Error injection on byte 2, constant payload, two frames
    setup(11'd5, 8'd2, 2'b01, 8'hA5, 1'b1, 11'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    pos = 0; er_cnt = 0; en_cnt = 0; prev_en = 1'b0; n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
      if (TX_EN) begin
        pos = prev_en ? pos + 1 : 0;
        en_cnt++;
        if (pos >= 8) chk("s3_data", 32'(TXD), 32'hA5);
        if (TX_ER) begin
          er_cnt++;
          chk("s3_er_pos", 32'(pos), 32'd10);
        end
      end else begin
        chk("s3_er_idle", 32'(TX_ER), 32'd0);
      end
      prev_en = TX_EN;
    end
    chk("s3_done", 32'(done), 32'd1);
    chk("s3_er_cnt", 32'(er_cnt), 32'd2);
    chk("s3_en_cnt", 32'(en_cnt), 32'd26);
    chk("s3_frames", 32'(frames_sent), 32'd2);
    tick();

    // Zero-length payload: preamble plus SFD only
    setup(11'd0, 8'd1, 2'b00, 8'h00, 1'b1, 11'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    en_cnt = 0; n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
      if (TX_EN) en_cnt++;
      chk("s4_er", 32'(TX_ER), 32'd0);
    end
    chk("s4_done", 32'(done), 32'd1);
    chk("s4_en_cnt", 32'(en_cnt), 32'd8);
    tick();

    // Zero frames: straight to FIN
    setup(11'd4, 8'd0, 2'b00, 8'h00, 1'b0, 11'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s4z_done", 32'(done), 32'd1);
    chk("s4z_busy", 32'(busy), 32'd1);
    chk("s4z_en", 32'(TX_EN), 32'd0);
    tick();
    chk("s4z_done_off", 32'(done), 32'd0);
    chk("s4z_idle", 32'(busy), 32'd0);
    chk("s4z_en2", 32'(TX_EN), 32'd0);

    // Reset during payload byte 2
    setup(11'd6, 8'd1, 2'b00, 8'h20, 1'b0, 11'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("s5_b1", 32'(TXD), 32'h21);
    mr_main_reset = 1'b0;
    tick();
    chk("s5_en", 32'(TX_EN), 32'd0);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_frames", 32'(frames_sent), 32'd0);
    chk("s5_done", 32'(done), 32'd0);
    mr_main_reset = 1'b1;
    tick();
    chk("s5_still_idle", 32'(busy), 32'd0);
    chk("s5_no_done", 32'(done), 32'd0);
    setup(11'd2, 8'd1, 2'b00, 8'h30, 1'b0, 11'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_b = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'(8'h30 + i - 8);
      chk("s5_txd", 32'(TXD), 32'(exp_b));
      chk("s5_txen", 32'(TX_EN), 32'd1);
    end
    wait_done("s5_redo_done", n);
    chk("s5_redo_frames", 32'(frames_sent), 32'd1);
    tick();

    // start held high across two bursts
    setup(11'd1, 8'd1, 2'b00, 8'h40, 1'b0, 11'd0);
    start = 1'b1;
    tick();
    wait_done("s6_done1", n);
    chk("s6_len1", 32'(n), 32'd21);
    chk("s6_frames1", 32'(frames_sent), 32'd1);
    tick();
    chk("s6_idle", 32'(busy), 32'd0);
    tick();
    chk("s6_restart", 32'(busy), 32'd1);
    chk("s6_frames_clr", 32'(frames_sent), 32'd0);
    tick();
    chk("s6_en2", 32'(TX_EN), 32'd1);
    chk("s6_txd2", 32'(TXD), 32'h55);
    start = 1'b0;
    wait_done("s6_done2", n);
    chk("s6_frames2", 32'(frames_sent), 32'd1);
    tick();
    chk("s6_end_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
